// File: rtl/imem_pkg.sv
// ----------------------------------------------------------------------------
// imem_pkg
// Shared types, constants and helpers for the instruction-memory responder.
//   imem_state_e : responder FSM states (IDLE, WAIT)
//   IMEM_BAD_*   : encodings of the {access_fault, page_fault} response field
//   region_hit() : unsigned "is this address inside the region" compare
// ----------------------------------------------------------------------------
package imem_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } imem_state_e;

    localparam logic [1:0] IMEM_BAD_NONE   = 2'b00;
    localparam logic [1:0] IMEM_BAD_ACCESS = 2'b10;

    // The subtraction is done modulo 2**addr_w, so an address below the base
    // wraps to a huge offset and falls outside the region.
    function automatic logic region_hit(
        input logic [63:0] addr,
        input logic [63:0] base,
        input int unsigned addr_w,
        input int unsigned size_w
    );
        logic [63:0] diff;
        logic [63:0] mask;
        mask = (addr_w >= 64) ? '1 : ((64'd1 << addr_w) - 64'd1);
        diff = (addr - base) & mask;
        if (size_w >= 64) begin
            return 1'b1;
        end
        return (diff >> size_w) == 64'd0;
    endfunction

endpackage

// File: rtl/imem_par_chk.sv
// ----------------------------------------------------------------------------
// imem_par_chk
// Combinational per-byte even-parity checker for SRAM read data.
// Ports:
//   data : SRAM read word
//   par  : one even-parity bit per byte of data
//   err  : 1 when any byte together with its parity bit has odd weight
// ----------------------------------------------------------------------------
module imem_par_chk #(
    parameter int DATA_W = 32
) (
    input  logic [DATA_W-1:0]   data,
    input  logic [DATA_W/8-1:0] par,
    output logic                err
);

    always_comb begin
        err = 1'b0;
        for (int i = 0; i < DATA_W / 8; i++) begin
            if (^{data[i*8 +: 8], par[i]}) begin
                err = 1'b1;
            end
        end
    end

endmodule

// File: rtl/imem_slv.sv
// ----------------------------------------------------------------------------
// imem_slv
// Slave end of the instruction fetch port. Fronts a 1-cycle-latency SRAM,
// inserts WAIT_CYC busy cycles per access and range-checks every address;
// out-of-range fetches return an access fault without strobing the SRAM.
// Optional feature macro: IMEM_PARITY_EN (per-byte SRAM parity checking).
// Ports:
//   clk, rst    : clock, synchronous active-high reset
//   imem_req    : fetch request (accepted when imem_busy is low)
//   imem_addr   : fetch byte address, bits [1:0] ignored
//   imem_rdata  : fetch response data
//   imem_bad    : {access_fault, page_fault}; page_fault is always 0
//   imem_busy   : responder busy, response pending
//   sram_cs     : SRAM read strobe (acceptance cycle, in-range only)
//   sram_addr   : SRAM word address
//   sram_rdata  : SRAM data, valid the cycle after sram_cs
//   sram_par    : per-byte even parity of sram_rdata
// ----------------------------------------------------------------------------
module imem_slv
    import imem_pkg::*;
#(
    parameter int                ADDR_W   = 32,
    parameter int                DATA_W   = 32,
    parameter logic [ADDR_W-1:0] BASE     = '0,
    parameter int                SIZE_W   = 16,
    parameter int                WAIT_CYC = 0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                imem_req,
    input  logic [ADDR_W-1:0]   imem_addr,
    output logic [DATA_W-1:0]   imem_rdata,
    output logic [1:0]          imem_bad,
    output logic                imem_busy,
    output logic                sram_cs,
    output logic [SIZE_W-3:0]   sram_addr,
    input  logic [DATA_W-1:0]   sram_rdata,
    input  logic [DATA_W/8-1:0] sram_par
);

    localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYC);
    localparam bit         PASS_THRU = (WAIT_CYC == 0);

    imem_state_e       state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              cap_q, cap_d;
    logic              hit_q, hit_d;
    logic [DATA_W-1:0] hold_rdata_q, hold_rdata_d;
    logic [1:0]        hold_bad_q, hold_bad_d;

    logic              accept;
    logic              in_range;
    logic              par_err;
    logic [DATA_W-1:0] resp_rdata;
    logic [1:0]        resp_bad;

    // Parity checking is only compiled in when the feature is enabled; the
    // sram_par port stays in the port list either way.
`ifdef IMEM_PARITY_EN
    imem_par_chk #(
        .DATA_W (DATA_W)
    ) u_par_chk (
        .data (sram_rdata),
        .par  (sram_par),
        .err  (par_err)
    );
`else
    logic unused_par;
    assign unused_par = ^sram_par;
    assign par_err    = 1'b0;
`endif

    assign imem_busy = (state_q == WAIT);
    assign accept    = imem_req && !imem_busy;
    assign in_range  = region_hit(64'(imem_addr), 64'(BASE), ADDR_W, SIZE_W);
    assign sram_cs   = accept && in_range;
    assign sram_addr = imem_addr[SIZE_W-1:2];

    // Response as seen in the cycle after acceptance (cap_q high). A miss
    // never read the SRAM, so its data is forced to zero.
    always_comb begin
        resp_rdata = '0;
        resp_bad   = IMEM_BAD_ACCESS;
        if (hit_q) begin
            resp_rdata = sram_rdata;
            resp_bad   = par_err ? IMEM_BAD_ACCESS : IMEM_BAD_NONE;
        end
    end

    // With no wait states the response cycle is the SRAM data cycle, so the
    // data is passed straight through; otherwise it comes from the hold regs.
    always_comb begin
        imem_rdata = hold_rdata_q;
        imem_bad   = hold_bad_q;
        if (PASS_THRU && cap_q) begin
            imem_rdata = resp_rdata;
            imem_bad   = resp_bad;
        end
    end

    // Next-state logic: acceptance bookkeeping, hold capture and the
    // IDLE/WAIT busy sequencer.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        cap_d        = 1'b0;
        hit_d        = hit_q;
        hold_rdata_d = hold_rdata_q;
        hold_bad_d   = hold_bad_q;

        if (accept) begin
            cap_d = 1'b1;
            hit_d = in_range;
        end

        if (cap_q) begin
            hold_rdata_d = resp_rdata;
            hold_bad_d   = resp_bad;
        end

        case (state_q)
            IDLE: begin
                if (accept && !PASS_THRU) begin
                    state_d = WAIT;
                    cnt_d   = WAIT_INIT;
                end
            end
            WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q <= 4'd1) begin
                    state_d = IDLE;
                    cnt_d   = 4'd0;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = 4'd0;
            end
        endcase
    end

    // State register; reset drops any in-flight access and clears the hold.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            cnt_q        <= 4'd0;
            cap_q        <= 1'b0;
            hit_q        <= 1'b0;
            hold_rdata_q <= '0;
            hold_bad_q   <= IMEM_BAD_NONE;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            cap_q        <= cap_d;
            hit_q        <= hit_d;
            hold_rdata_q <= hold_rdata_d;
            hold_bad_q   <= hold_bad_d;
        end
    end

endmodule

// File: doc/imem_slv.md
Name: imem_slv

Overview:
Instruction-side memory responder. It is the slave end of the fetch port (imem_req/imem_addr in, imem_rdata/imem_bad/imem_busy out) that the fetch unit and prefetch buffer drive. It fronts a single-port, 1-cycle-latency instruction SRAM, inserts programmable wait states, and range-checks every address. Out-of-range fetches return an access fault and never touch the SRAM.

Parameters:
ADDR_W, 32, fetch address width
DATA_W, 32, fetch data width; one word per response
BASE, 32'h0000_0000, region base address; aligned to 2**SIZE_W
SIZE_W, 16, log2 of region size in bytes
WAIT_CYC, 0, extra busy cycles per access (0..15)

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
imem_req  in  1  fetch request
imem_addr  in  ADDR_W  fetch byte address; bits [1:0] ignored (word fetch)
imem_rdata  out  DATA_W  fetch data
imem_bad  out  2  {access_fault, page_fault}; page_fault is always 0
imem_busy  out  1  responder not ready / response pending
sram_cs  out  1  SRAM read strobe
sram_addr  out  SIZE_W-2  SRAM word address
sram_rdata  in  DATA_W  SRAM data, valid the cycle after sram_cs
sram_par  in  DATA_W/8  per-byte even parity (used only with IMEM_PARITY_EN)

Behaviour:
- Clock and reset: single clock clk. Reset rst is synchronous and active-high.
- Reset values: state IDLE, imem_busy=0, imem_rdata=0, imem_bad=0, sram_cs=0, wait counter=0.
- Acceptance: a request is accepted in any cycle with imem_req=1 and imem_busy=0. The address is registered at acceptance.
- In range: (imem_addr - BASE) < 2**SIZE_W, using an unsigned ADDR_W compare.
  - Combinationally in the acceptance cycle: sram_cs=1, sram_addr=imem_addr[SIZE_W-1:2].
  - Out-of-range acceptance: sram_cs=0.
- Response cycle: the first cycle after acceptance in which imem_busy=0.
  - WAIT_CYC=0: the response cycle is N+1 for acceptance at N, so back-to-back requests run at 1 per cycle.
  - WAIT_CYC=k: imem_busy=1 for cycles N+1..N+k; the response cycle is N+k+1.
- Response contents:
  - In-range hit: imem_rdata = word read, imem_bad=2'b00.
  - Out-of-range: imem_rdata=0, imem_bad=2'b10.
- Data path: sram_rdata is captured into a hold register in cycle N+1.
  - imem_rdata = sram_rdata while in cycle N+1 with WAIT_CYC=0; otherwise it comes from the hold register.
  - After the response cycle, imem_rdata/imem_bad hold the last response until the next response cycle.
- State machine:
  - IDLE: accept → if WAIT_CYC=0, stay IDLE (response is implicit next cycle); else go to WAIT with counter=WAIT_CYC.
  - WAIT: imem_busy=1; decrement the counter; at 1 → IDLE.
  - An accept in IDLE is permitted in the same cycle as a response.
- Request changes during busy: imem_req or imem_addr changing while imem_busy=1 is ignored. The in-flight access completes with its registered address.
- Dropped request: the fetch side dropping imem_req during busy (jump/flush) does not cancel the access. The response is still produced, and the requester discards it.
- Reset mid-access: immediately returns to IDLE with busy=0. The pending response is never delivered and the hold register clears to 0.
- Address wrap: addresses below BASE wrap in the subtraction and produce a large value, so they are out-of-range.

Optional Feature:
IMEM_PARITY_EN
- Defined: in cycle N+1 each byte of sram_rdata is checked against sram_par; any mismatch makes the response imem_bad=2'b10.
  - imem_rdata is still the raw word.
  - The error flag is held with the data.
- Undefined: sram_par is ignored (port still present), no parity logic, in-range responses always have imem_bad=2'b00.

Decomposition:
- Shared package (imem_pkg):
  - state enum {IDLE, WAIT};
  - IMEM_BAD_ACCESS=2'b10, IMEM_BAD_NONE=2'b00;
  - function for the region-hit compare.
- One natural sub-module: imem_par_chk, a combinational per-byte parity checker instantiated under IMEM_PARITY_EN.

Test Plan:
- WAIT_CYC=0, BASE=0: req at 0x0,0x4,0x8 on consecutive cycles → busy stays 0; rdata = SRAM words 0..2 in cycles N+1..N+3; bad=00.
- WAIT_CYC=2: req 0x10 at cycle 5 → busy=1 in cycles 6-7; rdata valid with busy=0 in cycle 8; a second request in cycle 6 is ignored.
- BASE=0x8000_0000, SIZE_W=16: req at 0x8001_0000 and at 0x7FFF_FFFC → sram_cs never asserted; bad=10, rdata=0.
- WAIT_CYC=3: rst asserted in the 2nd busy cycle → next cycle busy=0, rdata=0, bad=00; a fresh request is accepted the cycle after rst drops.
- IMEM_PARITY_EN: SRAM word 0xA5A5_A5A5 with byte-1 parity flipped → bad=10, rdata=0xA5A5_A5A5; correct parity → bad=00.
- Request toggling: imem_req dropped and imem_addr changed during busy → the original address's data is returned; no extra sram_cs.
